uart_rx_frontend: RTL

//   Receive front-end of the serial RX path; sits directly upstream of the serial-in/parallel-out stage.

---
 rtl/uart_rx_frontend.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front-end: rx synchroniser, start-bit validation and mid-bit
// sample timing from an oversampling counter. Feeds a downstream shifter that
// captures bit_o on every sample_o strobe.
module uart_rx_frontend #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic start_o,
    output logic sample_o,
    output logic bit_o,
    output logic done_o,
    output logic frame_err_o,
    output logic busy_o
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_MID_PRE  = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] TICK_LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST_PRE = TW'(OVERSAMPLE - 2);
    localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic                   bit_q, bit_d;
    logic                   sample_q, sample_d;
    logic                   start_q, start_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q;
    logic                   rx_s;
    logic                   rx_pre;

    // rx_s is the synchronised line; rx_pre is the value rx_s takes next
    // cycle, which lets the start/stop verdicts be registered yet still line
    // up with the cycle in which rx_s is actually checked.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign rx_pre = sync_q[SYNC_STAGES-2];

    // Next-state, counter and pulse decode.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        bit_d     = bit_q;
        sample_d  = 1'b0;
        start_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d    = {TW{1'b0}};
                bit_idx_d = {BW{1'b0}};
                if (rx_q && !rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_q == TICK_MID_PRE && !rx_pre) begin
                    start_d = 1'b1;
                end else begin
                    start_d = 1'b0;
                end
                if (tick_q == TICK_MID) begin
                    tick_d    = {TW{1'b0}};
                    bit_idx_d = {BW{1'b0}};
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d   = {TW{1'b0}};
                    bit_d    = rx_s;
                    sample_d = 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP: begin
                if (tick_q == TICK_LAST_PRE) begin
                    done_d = rx_pre;
                    err_d  = !rx_pre;
                end else begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end
                if (tick_q == TICK_LAST) begin
                    tick_d = {TW{1'b0}};
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = BRK;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            BRK: begin
                tick_d = {TW{1'b0}};
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BRK;
                end
            end
            default: begin
                state_d   = IDLE;
                tick_d    = {TW{1'b0}};
                bit_idx_d = {BW{1'b0}};
            end
        endcase
    end

    // State, synchroniser, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sync_q    <= {SYNC_STAGES{1'b1}};
            rx_q      <= 1'b1;
            tick_q    <= {TW{1'b0}};
            bit_idx_q <= {BW{1'b0}};
            bit_q     <= 1'b1;
            sample_q  <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            rx_q      <= rx_s;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            bit_q     <= bit_d;
            sample_q  <= sample_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign start_o     = start_q;
    assign sample_o    = sample_q;
    assign bit_o       = bit_q;
    assign done_o      = done_q;
    assign frame_err_o = err_q;
    assign busy_o      = busy_q;

endmodule
